// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
// Background scrubber for an ECC-protected RAM. Sweeps word addresses
// 0..cfg_last_addr. Each word is read (data + check bits) and passed through
// the external decoder. A corrected single-bit error is re-encoded and
// written back to the same address. An uncorrectable word raises irq_ue and
// is counted.
//
// Optional feature (compile-time macro ECC_SCRUB_STOP_ON_UE_EN):
//   defined   - an uncorrectable word ends the sweep at once (done pulses,
//               then busy falls).
//   undefined - the sweep continues past uncorrectable words.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   start, abort                  sweep control pulses
//   cfg_last_addr, cfg_interval   sweep bound and idle gap; sampled on start
//   mem_req/we/addr/wdata/wecc    RAM request, held stable until mem_gnt
//   mem_gnt, mem_rvalid,
//   mem_rdata, mem_recc           RAM grant and read-return channel
//   dec_data_in/dec_ecc_in        decoder inputs
//   dec_data_out/dec_err_sts      decoder outputs
//   enc_data_in                   encoder input
//   enc_data_out/enc_ecc_out      encoder outputs
//   busy, done, irq_ue            status; done and irq_ue are 1-cycle pulses
//   cnt_corr, cnt_uncorr          saturating word counters, cleared on start
//   last_err_addr                 address of the most recent non-clean status
module ecc_scrub_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int ECC_WIDTH  = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int DEC_LAT    = 1,
   parameter int ENC_LAT    = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] cfg_last_addr,
   input  logic [15:0]           cfg_interval,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [ECC_WIDTH-1:0]  mem_wecc,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic [ECC_WIDTH-1:0]  mem_recc,
   output logic [DATA_WIDTH-1:0] dec_data_in,
   output logic [ECC_WIDTH-1:0]  dec_ecc_in,
   input  logic [DATA_WIDTH-1:0] dec_data_out,
   input  logic [1:0]            dec_err_sts,
   output logic [DATA_WIDTH-1:0] enc_data_in,
   input  logic [DATA_WIDTH-1:0] enc_data_out,
   input  logic [ECC_WIDTH-1:0]  enc_ecc_out,
   output logic                  busy,
   output logic                  done,
   output logic                  irq_ue,
   output logic [CNT_WIDTH-1:0]  cnt_corr,
   output logic [CNT_WIDTH-1:0]  cnt_uncorr,
   output logic [ADDR_WIDTH-1:0] last_err_addr
);

   localparam int LAT_W = 8;
   localparam logic [LAT_W-1:0] DEC_LAT_C = LAT_W'(DEC_LAT);
   localparam logic [LAT_W-1:0] ENC_LAT_C = LAT_W'(ENC_LAT);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_DEC, S_ENC, S_WR_REQ, S_NEXT, S_GAP, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] last_q, last_d;
   logic [15:0]           intv_q, intv_d;
   logic [15:0]           gap_q, gap_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic                  abort_q, abort_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [ECC_WIDTH-1:0]  recc_q, recc_d;
   logic [DATA_WIDTH-1:0] corr_q, corr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [ECC_WIDTH-1:0]  wecc_q, wecc_d;
   logic [CNT_WIDTH-1:0]  ccorr_q, ccorr_d;
   logic [CNT_WIDTH-1:0]  cunc_q, cunc_d;
   logic [ADDR_WIDTH-1:0] lerr_q, lerr_d;
   logic                  irq_q, irq_d;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         last_q  <= '0;
         intv_q  <= '0;
         gap_q   <= '0;
         lat_q   <= '0;
         abort_q <= 1'b0;
         rdata_q <= '0;
         recc_q  <= '0;
         corr_q  <= '0;
         wdata_q <= '0;
         wecc_q  <= '0;
         ccorr_q <= '0;
         cunc_q  <= '0;
         lerr_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         intv_q  <= intv_d;
         gap_q   <= gap_d;
         lat_q   <= lat_d;
         abort_q <= abort_d;
         rdata_q <= rdata_d;
         recc_q  <= recc_d;
         corr_q  <= corr_d;
         wdata_q <= wdata_d;
         wecc_q  <= wecc_d;
         ccorr_q <= ccorr_d;
         cunc_q  <= cunc_d;
         lerr_q  <= lerr_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      last_d  = last_q;
      intv_d  = intv_q;
      gap_d   = gap_q;
      lat_d   = lat_q;
      rdata_d = rdata_q;
      recc_d  = recc_q;
      corr_d  = corr_q;
      wdata_d = wdata_q;
      wecc_d  = wecc_q;
      ccorr_d = ccorr_q;
      cunc_d  = cunc_q;
      lerr_d  = lerr_q;
      irq_d   = 1'b0;
      // An abort pulse is remembered in every busy state and acted on only
      // at the word boundary, so an in-flight write-back always completes.
      abort_d = abort_q | (abort & (state_q != S_IDLE));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD_REQ;
               addr_d  = '0;
               last_d  = cfg_last_addr;
               intv_d  = cfg_interval;
               ccorr_d = '0;
               cunc_d  = '0;
               abort_d = 1'b0;
            end
         end
         S_RD_REQ: begin
            if (mem_gnt) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (mem_rvalid) begin
               rdata_d = mem_rdata;
               recc_d  = mem_recc;
               lat_d   = '0;
               state_d = S_DEC;
            end
         end
         S_DEC: begin
            // The decoder inputs come straight from the capture registers,
            // so its result is valid exactly DEC_LAT cycles into this state.
            if (lat_q == DEC_LAT_C) begin
               lat_d = '0;
               if (dec_err_sts != 2'b00) lerr_d = addr_q;
               case (dec_err_sts)
                  2'b00: state_d = S_NEXT;
                  2'b01: begin
                     corr_d  = dec_data_out;
                     state_d = S_ENC;
                  end
                  default: begin
                     irq_d  = 1'b1;
                     cunc_d = sat_inc(cunc_q);
`ifdef ECC_SCRUB_STOP_ON_UE_EN
                     state_d = S_DONE;
`else
                     state_d = S_NEXT;
`endif
                  end
               endcase
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_ENC: begin
            if (lat_q == ENC_LAT_C) begin
               wdata_d = enc_data_out;
               wecc_d  = enc_ecc_out;
               state_d = S_WR_REQ;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_WR_REQ: begin
            if (mem_gnt) begin
               ccorr_d = sat_inc(ccorr_q);
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (addr_q == last_q || abort_q || abort) begin
               state_d = S_DONE;
            end else begin
               addr_d = addr_q + 1'b1;
               if (intv_q == 16'd0) begin
                  state_d = S_RD_REQ;
               end else begin
                  gap_d   = intv_q - 16'd1;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == 16'd0) state_d = S_RD_REQ;
            else gap_d = gap_q - 16'd1;
         end
         S_DONE: begin
            abort_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request lines decode directly from the state register so that an
   // asynchronous reset withdraws a pending request immediately.
   assign mem_req       = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
   assign mem_we        = (state_q == S_WR_REQ);
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_wecc      = wecc_q;
   assign dec_data_in   = rdata_q;
   assign dec_ecc_in    = recc_q;
   assign enc_data_in   = corr_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign irq_ue        = irq_q;
   assign cnt_corr      = ccorr_q;
   assign cnt_uncorr    = cunc_q;
   assign last_err_addr = lerr_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
module tb_ecc_scrub_ctrl;
   localparam int DW   = 64;
   localparam int EW   = 8;
   localparam int AW   = 10;
   localparam int CW   = 3;
   localparam int MEMN = 64;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [EW-1:0] e;
   } wr_t;

   logic          clk = 1'b0;
   logic          rstn, start, abort;
   logic [AW-1:0] cfg_last_addr;
   logic [15:0]   cfg_interval;
   logic          mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [EW-1:0] mem_wecc, mem_recc;
   logic [DW-1:0] dec_data_in, dec_data_out, enc_data_in, enc_data_out;
   logic [EW-1:0] dec_ecc_in, enc_ecc_out;
   logic [1:0]    dec_err_sts;
   logic          busy, done, irq_ue;
   logic [CW-1:0] cnt_corr, cnt_uncorr;
   logic [AW-1:0] last_err_addr;

   always #5 clk = ~clk;

   ecc_scrub_ctrl #(
      .DATA_WIDTH(DW), .ECC_WIDTH(EW), .ADDR_WIDTH(AW),
      .DEC_LAT(1), .ENC_LAT(1), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .cfg_last_addr(cfg_last_addr), .cfg_interval(cfg_interval),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wecc(mem_wecc), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_recc(mem_recc),
      .dec_data_in(dec_data_in), .dec_ecc_in(dec_ecc_in),
      .dec_data_out(dec_data_out), .dec_err_sts(dec_err_sts),
      .enc_data_in(enc_data_in), .enc_data_out(enc_data_out), .enc_ecc_out(enc_ecc_out),
      .busy(busy), .done(done), .irq_ue(irq_ue),
      .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr), .last_err_addr(last_err_addr)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Hamming SECDED over 64 data bits: 7 position-syndrome bits plus an
   // overall parity bit in ecc[7].
   function automatic logic [7:0] enc_f(input logic [63:0] d);
      logic [6:0] c;
      int k;
      c = '0;
      k = 0;
      for (int p = 1; p < 72; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (d[k]) c = c ^ 7'(p);
            k++;
         end
      end
      return {(^d) ^ (^c), c};
   endfunction

   function automatic logic [65:0] dec_f(input logic [63:0] d, input logic [7:0] e, input logic alt);
      logic [7:0]  r;
      logic [6:0]  syn;
      logic        par;
      logic [63:0] cd;
      int k;
      r   = enc_f(d);
      syn = r[6:0] ^ e[6:0];
      par = (^d) ^ (^e);
      cd  = d;
      k   = 0;
      if (!par && syn == 7'd0) return {2'b00, d};
      if (!par) return {(alt ? 2'b11 : 2'b10), d};
      for (int p = 1; p < 72; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (7'(p) == syn) cd[k] = ~cd[k];
            k++;
         end
      end
      return {2'b01, cd};
   endfunction

   always @(posedge clk)
      {dec_err_sts, dec_data_out} <= dec_f(dec_data_in, dec_ecc_in, 1'($urandom_range(0, 1)));

   always @(posedge clk) begin
      enc_data_out <= enc_data_in;
      enc_ecc_out  <= enc_f(enc_data_in);
   end

   logic [DW-1:0] gold  [MEMN];
   logic [DW-1:0] mem_d [MEMN];
   logic [EW-1:0] mem_e [MEMN];
   logic [AW-1:0] obs_rd[$], exp_rd[$];
   wr_t           obs_wr[$], exp_wr[$];
   int            rv_cnt  = 0;
   int            wr_hold = 0;
   logic [AW-1:0] model_last_err = '0;

   // RAM / arbiter model: random grants, read data 1..3 cycles after grant.
   initial begin : responder
      int       rd_cnt, rd_idx, hold_cnt;
      bit       prev_stall;
      logic [83:0] prev_bus;
      rd_cnt = 0; rd_idx = 0; hold_cnt = 0; prev_stall = 0; prev_bus = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_recc = '0;
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (!rstn) begin
            rd_cnt = 0; hold_cnt = 0; prev_stall = 0; mem_gnt = 1'b0;
         end else begin
            if (rd_cnt > 0) begin
               rd_cnt--;
               if (rd_cnt == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = mem_d[rd_idx];
                  mem_recc   = mem_e[rd_idx];
                  rv_cnt++;
               end
            end
            if (prev_stall)
               check("req_stable", {mem_req, mem_we, mem_addr, mem_wdata, mem_wecc}, prev_bus);
            mem_gnt = 1'b0;
            if (mem_req) begin
               if (mem_we && hold_cnt < wr_hold) hold_cnt++;
               else mem_gnt = ($urandom_range(0, 99) < 60);
            end
            if (mem_req && mem_gnt) begin
               hold_cnt = 0;
               if (mem_we) begin
                  obs_wr.push_back({mem_addr, mem_wdata, mem_wecc});
                  mem_d[mem_addr[5:0]] = mem_wdata;
                  mem_e[mem_addr[5:0]] = mem_wecc;
               end else begin
                  obs_rd.push_back(mem_addr);
                  rd_idx = int'(mem_addr[5:0]);
                  rd_cnt = $urandom_range(1, 3);
               end
            end
            prev_stall = mem_req && !mem_gnt;
            prev_bus   = {mem_req, mem_we, mem_addr, mem_wdata, mem_wecc};
         end
      end
   end

   task automatic do_reset();
      rstn = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_last_addr = '0; cfg_interval = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", {mem_req, mem_we, busy, done, irq_ue}, '0);
      check("rst_bus", {mem_addr, mem_wdata, mem_wecc}, '0);
      check("rst_dec", {dec_data_in, dec_ecc_in}, '0);
      check("rst_enc", enc_data_in, '0);
      check("rst_cnt", {cnt_corr, cnt_uncorr, last_err_addr}, '0);
      rstn = 1'b1;
      model_last_err = '0;
      @(posedge clk); #1;
   endtask

   task automatic init_mem();
      for (int a = 0; a < MEMN; a++) begin
         gold[a]  = {$urandom, $urandom};
         mem_d[a] = gold[a];
         mem_e[a] = enc_f(gold[a]);
      end
   endtask

   task automatic flip1(input int a);
      mem_d[a] = mem_d[a] ^ (64'd1 << $urandom_range(0, 63));
   endtask

   task automatic flip2(input int a);
      int b1, b2;
      b1 = $urandom_range(0, 63);
      b2 = (b1 + 1 + $urandom_range(0, 62)) % 64;
      mem_d[a] = mem_d[a] ^ (64'd1 << b1) ^ (64'd1 << b2);
   endtask

   // abort_mode: 0 none, 1 abort together with start, 2 abort pulsed while idle
   task automatic run_sweep(input int last, input int intv, input int abort_at,
                            input int abort_mode, input bit disturb);
      int corr, unc, irqs_exp, irqs, n, ab_cd;
      bit got_done, ab_done;
      corr = 0; unc = 0; irqs_exp = 0; irqs = 0; n = 0; ab_cd = 0;
      got_done = 0; ab_done = 0;
      exp_rd.delete(); exp_wr.delete();
      // Reference: walk the words in order and classify each one by how many
      // bits differ from the known-good content.
      for (int a = 0; a <= last; a++) begin
         int flips;
         flips = $countones(mem_d[a] ^ gold[a]);
         exp_rd.push_back(AW'(a));
         if (flips == 1) begin
            exp_wr.push_back({AW'(a), gold[a], enc_f(gold[a])});
            corr++;
            model_last_err = AW'(a);
         end else if (flips >= 2) begin
            unc++;
            irqs_exp++;
            model_last_err = AW'(a);
`ifdef ECC_SCRUB_STOP_ON_UE_EN
            break;
`endif
         end
         if (a == abort_at) break;
      end
      obs_rd.delete(); obs_wr.delete(); rv_cnt = 0;

      @(posedge clk); #1;
      if (abort_mode == 2) begin
         abort = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
      end
      cfg_last_addr = AW'(last);
      cfg_interval  = 16'(intv);
      start = 1'b1;
      abort = (abort_mode == 1);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      cfg_last_addr = AW'($urandom_range(0, 7));
      cfg_interval  = 16'($urandom_range(0, 5));
      check("busy_after_start", busy, 1'b1);
      check("cnt_cleared", {cnt_corr, cnt_uncorr}, '0);

      while (!got_done && n < 5000) begin
         if (irq_ue) irqs++;
         if (done) got_done = 1;
         if (abort_at >= 0 && !ab_done) begin
            if (ab_cd == 0 && rv_cnt > abort_at) ab_cd = 1;
            else if (ab_cd > 0) begin
               ab_cd++;
               if (ab_cd == 3) abort = 1'b1;
               if (ab_cd == 4) begin abort = 1'b0; ab_done = 1; end
            end
         end
         if (disturb && n == 6) begin start = 1'b1; cfg_last_addr = '0; end
         if (disturb && n == 7) start = 1'b0;
         if (!got_done) begin
            @(posedge clk); #1;
            n++;
         end
      end
      abort = 1'b0; start = 1'b0;
      check("done_seen", got_done, 1'b1);
      if (!got_done) begin
         do_reset();
      end else begin
         @(posedge clk); #1;
         check("done_pulse_busy", {done, busy}, 2'b00);
         repeat (3) @(posedge clk);
         #1;
         check("rd_count", obs_rd.size(), exp_rd.size());
         for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            check("rd_addr", obs_rd[i], exp_rd[i]);
         check("wr_count", obs_wr.size(), exp_wr.size());
         for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            check("wr_word", obs_wr[i], exp_wr[i]);
         check("cnt_corr", cnt_corr, (corr > CMAX) ? CMAX : corr);
         check("cnt_uncorr", cnt_uncorr, (unc > CMAX) ? CMAX : unc);
         check("irq_pulses", irqs, irqs_exp);
         check("last_err_addr", last_err_addr, model_last_err);
      end
   endtask

   task automatic rst_in_write();
      int n;
      init_mem();
      flip1(0);
      wr_hold = 1000000;
      obs_wr.delete();
      @(posedge clk); #1;
      cfg_last_addr = AW'(3); cfg_interval = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(mem_req && mem_we) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("wr_req_reached", {mem_req, mem_we}, 2'b11);
      repeat (2) @(posedge clk);
      #3 rstn = 1'b0;
      #1;
      check("async_rst_req", {mem_req, mem_we, busy, done, irq_ue}, '0);
      check("async_rst_bus", {mem_addr, mem_wdata, mem_wecc}, '0);
      check("async_rst_cnt", {cnt_corr, cnt_uncorr, last_err_addr}, '0);
      check("no_partial_write", obs_wr.size(), 0);
      wr_hold = 0;
      @(posedge clk); #1;
      rstn = 1'b1;
      model_last_err = '0;
      run_sweep(3, 0, -1, 0, 0);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int last;
      do_reset();

      init_mem();
      run_sweep(3, 0, -1, 0, 0);

      init_mem();
      mem_d[2] = mem_d[2] ^ (64'd1 << 17);
      run_sweep(3, 0, -1, 0, 0);

      init_mem();
      mem_d[1] = mem_d[1] ^ (64'd1 << 24) ^ (64'd1 << 60);
      run_sweep(3, 0, -1, 0, 0);

      init_mem();
      flip1(2);
      wr_hold = 5;
      run_sweep(3, 1, -1, 0, 0);
      wr_hold = 0;

      init_mem();
      flip1(5);
      run_sweep(15, 0, 5, 0, 0);

      init_mem();
      flip1(4);
      run_sweep(7, 2, -1, 1, 0);

      init_mem();
      flip1(3);
      run_sweep(5, 0, -1, 2, 0);

      init_mem();
      flip1(2);
      flip2(6);
      run_sweep(10, 1, -1, 0, 1);

      init_mem();
      for (int a = 0; a < 10; a++) flip1(a);
      for (int a = 10; a < 20; a++) flip2(a);
      run_sweep(19, 0, -1, 0, 0);

      rst_in_write();

      for (int s = 0; s < 6; s++) begin
         init_mem();
         last = (s == 0) ? 0 : $urandom_range(1, 40);
         for (int a = 0; a <= last; a++) begin
            case ($urandom_range(0, 9))
               0, 1: flip1(a);
               2: flip2(a);
               default: ;
            endcase
         end
         run_sweep(last, $urandom_range(0, 3), (s == 5) ? $urandom_range(0, last) : -1, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
